ff_response_checker: RTL and testbench

- Synthesizable receive-side companion to the flip-flop conversion blocks (JK-to-SR, JK-to-T, JK-to-D).
- Observes the input pair and the Q output of a converted flip-flop under test and runs an internal golden next-state model.
- Compares DUT Q against the model every cycle and reports mismatches, counts and first-failure position.
- Sits beside the DUT in benches and on-board self-test, replacing $monitor-style eyeballing.

---
 rtl/ff_response_checker.sv | 135 +++++++++++++
 tb/tb_ff_response_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_response_checker.sv
// ff_response_checker
//   Receive-side checker for a converted flip-flop (SR, JK, D or T behaviour).
//   It watches the same input pair the flip-flop under test sees, runs its own
//   golden next-state model, and compares the model against the DUT Q on every
//   checking cycle. Mismatch count, compare count, first-failure position and a
//   sticky fail flag are reported.
//
// Parameters
//   MODE         flip-flop type modelled: 0=SR, 1=JK, 2=D, 3=T
//   CNT_W        width of every counter output
//   STOP_ON_FAIL 1 = freeze in the FAIL state on the first mismatch
//
// Ports
//   clk        rising-edge clock shared with the DUT
//   rst        asynchronous active-high reset
//   en         arm / keep checking; low returns to IDLE
//   in_a       S / J / D / T input seen by the DUT
//   in_b       R / K input seen by the DUT (unused for D and T)
//   dut_q      Q output of the DUT
//   exp_q      golden-model Q
//   err_pulse  one-cycle flag per mismatch
//   err_cnt    mismatch count (saturating)
//   chk_cnt    compares performed (saturating)
//   inv_cnt    SR cycles with S=R=1 (saturating, SR mode only)
//   first_err  chk_cnt value at the first mismatch
//   fail       sticky, set on the first mismatch
//   state      0=IDLE, 1=ALIGN, 2=CHECK, 3=FAIL
module ff_response_checker #(
  parameter int MODE         = 0,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             dut_q,
  output logic             exp_q,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic             fail,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  state_t st_q, st_d;
  logic   unknown;
  logic   sr_inv;
  logic   sr_def;
  logic   base_q;
  logic   cmp_ok;
  logic   mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // SR with S=R=1 returns q here; the unknown flag carries the real meaning.
  function automatic logic next_q(input logic q, input logic a, input logic b);
    case (MODE)
      0:       next_q = (a ^ b) ? a : q;
      1:       next_q = (a & b) ? ~q : ((a ^ b) ? a : q);
      2:       next_q = a;
      default: next_q = q ^ a;
    endcase
  endfunction

  assign sr_inv   = (MODE == 0) && in_a && in_b;
  assign sr_def   = (MODE == 0) && (in_a ^ in_b);
  // ALIGN seeds the model from the DUT; afterwards the model runs free.
  assign base_q   = (st_q == ST_ALIGN) ? dut_q : exp_q;
  assign cmp_ok   = (st_q == ST_CHECK) && !unknown;
  assign mismatch = cmp_ok && (dut_q != exp_q);
  assign state    = st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (en) st_d = ST_ALIGN;
      ST_ALIGN: st_d = en ? ST_CHECK : ST_IDLE;
      ST_CHECK: begin
        if ((STOP_ON_FAIL != 0) && mismatch) st_d = ST_FAIL;
        else if (!en)                        st_d = ST_IDLE;
      end
      default:  st_d = ST_FAIL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q     <= 1'b0;
      unknown   <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      inv_cnt   <= '0;
      first_err <= '0;
      fail      <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      if (cmp_ok) chk_cnt <= sat_inc(chk_cnt);
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        fail    <= 1'b1;
        // fail is sticky until reset, so it marks "first mismatch already seen"
        if (!fail) first_err <= chk_cnt;
      end
      if ((st_q == ST_ALIGN) || (st_q == ST_CHECK)) begin
        exp_q <= next_q(base_q, in_a, in_b);
        if (sr_inv) begin
          inv_cnt <= sat_inc(inv_cnt);
          unknown <= 1'b1;
        end else if ((st_q == ST_ALIGN) || sr_def) begin
          unknown <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ff_response_checker.sv
// Bench for ff_response_checker: four instances (SR/8-bit, JK/8-bit,
// D/2-bit counters, T/8-bit stop-on-fail) share clock, reset and inputs.
// Each sees its own emulated flip-flop output with optional fault injection,
// and a behavioural reference model predicts every output each cycle.
module tb_ff_response_checker;

  logic        clk;
  logic        rst;
  logic        en;
  logic        a;
  logic        b;
  logic        dq  [4];
  logic [31:0] eqv [4];
  logic [31:0] epv [4];
  logic [31:0] flv [4];
  logic [31:0] stv [4];
  logic [31:0] errc[4];
  logic [31:0] chkc[4];
  logic [31:0] invc[4];
  logic [31:0] fstc[4];

  typedef struct {
    int ph;
    bit q;
    bit unk;
    bit pulse;
    int err;
    int chk;
    int inv;
    int fst;
    bit fail;
  } mdl_t;

  mdl_t m  [4];
  bit   ffq[4];
  int   n_chk;
  int   n_fail;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 8;
    logic [CW-1:0] ec, cc, ic, fc;
    logic          e_q, e_p, f_l;
    logic [1:0]    s;
    ff_response_checker #(
      .MODE(g), .CNT_W(CW), .STOP_ON_FAIL((g == 3) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .en(en), .in_a(a), .in_b(b), .dut_q(dq[g]),
      .exp_q(e_q), .err_pulse(e_p), .err_cnt(ec), .chk_cnt(cc),
      .inv_cnt(ic), .first_err(fc), .fail(f_l), .state(s)
    );
    assign eqv[g]  = 32'(e_q);
    assign epv[g]  = 32'(e_p);
    assign flv[g]  = 32'(f_l);
    assign stv[g]  = 32'(s);
    assign errc[g] = 32'(ec);
    assign chkc[g] = 32'(cc);
    assign invc[g] = 32'(ic);
    assign fstc[g] = 32'(fc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic bit nxt(input int md, input bit q, input bit ia, input bit ib);
    case (md)
      0:       return (ia != ib) ? ia : q;
      1:       return (ia && ib) ? !q : ((ia != ib) ? ia : q);
      2:       return ia;
      default: return q ^ ia;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '{default: 0};
  endtask

  task automatic model_step(input int i, input bit e, input bit ia, input bit ib, input bit d);
    int mx;
    bit mis;
    mx  = (i == 2) ? 3 : 255;
    mis = 0;
    m[i].pulse = 0;
    case (m[i].ph)
      0: if (e) m[i].ph = 1;
      1: begin
        if (i == 0 && ia && ib) begin
          m[i].inv = sat(m[i].inv, mx);
          m[i].unk = 1;
        end else m[i].unk = 0;
        m[i].q  = nxt(i, d, ia, ib);
        m[i].ph = e ? 2 : 0;
      end
      2: begin
        if (!m[i].unk) begin
          mis = (d != m[i].q);
          if (mis) begin
            if (!m[i].fail) m[i].fst = m[i].chk;
            m[i].fail  = 1;
            m[i].err   = sat(m[i].err, mx);
            m[i].pulse = 1;
          end
          m[i].chk = sat(m[i].chk, mx);
        end
        if (i == 0 && ia && ib) begin
          m[i].inv = sat(m[i].inv, mx);
          m[i].unk = 1;
        end else begin
          if (i == 0 && ia != ib) m[i].unk = 0;
          m[i].q = nxt(i, m[i].q, ia, ib);
        end
        m[i].ph = (i == 3 && mis) ? 3 : (e ? 2 : 0);
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d.state", i),     stv[i],  32'(m[i].ph));
      check($sformatf("u%0d.exp_q", i),     eqv[i],  32'(m[i].q));
      check($sformatf("u%0d.err_pulse", i), epv[i],  32'(m[i].pulse));
      check($sformatf("u%0d.err_cnt", i),   errc[i], 32'(m[i].err));
      check($sformatf("u%0d.chk_cnt", i),   chkc[i], 32'(m[i].chk));
      check($sformatf("u%0d.inv_cnt", i),   invc[i], 32'(m[i].inv));
      check($sformatf("u%0d.first_err", i), fstc[i], 32'(m[i].fst));
      check($sformatf("u%0d.fail", i),      flv[i],  32'(m[i].fail));
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), predict the
  // coming rising edge, then compare on the next falling edge.
  task automatic cycle(input bit e, input bit ia, input bit ib, input int fault_rate);
    bit flip;
    en = e;
    a  = ia;
    b  = ib;
    for (int i = 0; i < 4; i++) begin
      flip  = (fault_rate > 0) && ($urandom_range(fault_rate - 1, 0) == 0);
      dq[i] = ffq[i] ^ flip;
      model_step(i, e, ia, ib, dq[i]);
      if (i == 0 && ia && ib) ffq[i] = bit'($urandom_range(1, 0));
      else                    ffq[i] = nxt(i, ffq[i], ia, ib);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_cycles(input int n, input int en_low, input int fault_rate);
    for (int k = 0; k < n; k++)
      cycle($urandom_range(15, 0) >= en_low, bit'($urandom_range(1, 0)),
            bit'($urandom_range(1, 0)), fault_rate);
  endtask

  logic [1:0] sr_seq[13];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    sr_seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01,
               2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    rst = 1'b1;
    en  = 1'b0;
    a   = 1'b0;
    b   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dq[i]  = 1'b0;
      ffq[i] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int k = 0; k < 13; k++) cycle(1'b1, sr_seq[k][1], sr_seq[k][0], 0);

    rand_cycles(300, 1, 0);
    rand_cycles(300, 1, 6);

    // asynchronous reset between edges while checking
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    #1 rst = 1'b0;

    rand_cycles(300, 4, 4);
    rand_cycles(100, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
